// File: rtl/tsw_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tsw_time_set_ctrl
//  Brief    : TSW debounce, seconds prescaler and RUN/SET_HOUR/SET_MIN mode
//             control for the digital clock counter chain.
//  Revision : 1.0 - initial release
// ============================================================================
module tsw_time_set_ctrl #(
    parameter int TICK_DIV  = 2048,
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 4096
) (
    input  logic       pCLK,
    input  logic       pRST,
    input  logic [7:0] TSW,
    output logic       sec_tick,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic [3:0] digit_blk
);

    localparam int c_TICK_W  = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int c_DB_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    localparam logic [1:0] c_RUN      = 2'b00;
    localparam logic [1:0] c_SET_HOUR = 2'b01;
    localparam logic [1:0] c_SET_MIN  = 2'b10;

    logic       w_unused_tsw;
    logic [2:0] w_ev;
    logic       w_mode_ev;
    logic       w_up_ev;
    logic       w_clr_ev;

    assign w_unused_tsw = ^TSW[7:3];

    // Per switch: 2-flop synchroniser, level filter, rising-edge press detect.
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic              r_s1;
        logic              r_s2;
        logic              r_acc;
        logic              r_acc_d;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge pCLK) begin
            if (pRST) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_acc   <= 1'b0;
                r_acc_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= ~TSW[i];
                r_s2    <= r_s1;
                r_acc_d <= r_acc;
                if (r_s2 != r_acc) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_acc <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_ev[i] = r_acc & ~r_acc_d;
    end

    assign w_mode_ev = w_ev[0];
    assign w_up_ev   = w_ev[1];
    assign w_clr_ev  = w_ev[2];

    logic [1:0]           r_mode;
    logic [1:0]           w_mode_nxt;
    logic                 w_hour_inc_nxt;
    logic                 w_min_inc_nxt;
    logic [3:0]           w_blk_nxt;
    logic                 w_phase_nxt;
    logic [c_BLINK_W-1:0] r_bcnt;
    logic                 r_phase;
    logic [c_TICK_W-1:0]  r_presc;
    logic                 r_sec_tick;
    logic                 r_min_inc;
    logic                 r_hour_inc;
    logic                 r_sec_clr;
    logic [3:0]           r_digit_blk;

    always_ff @(posedge pCLK) begin
        if (pRST) begin
            r_mode <= c_RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            c_RUN:      if (w_mode_ev) w_mode_nxt = c_SET_HOUR;
            c_SET_HOUR: if (w_mode_ev) w_mode_nxt = c_SET_MIN;
            c_SET_MIN:  if (w_mode_ev) w_mode_nxt = c_RUN;
            default:    w_mode_nxt = c_RUN;
        endcase
    end

    // UP acts on the mode in force before any simultaneous MODE transition.
    always_comb begin
        w_hour_inc_nxt = w_up_ev & (r_mode == c_SET_HOUR);
        w_min_inc_nxt  = w_up_ev & (r_mode == c_SET_MIN);
        w_phase_nxt    = (r_bcnt == c_BLINK_LAST) ? ~r_phase : r_phase;
        case (w_mode_nxt)
            c_SET_HOUR: w_blk_nxt = {w_phase_nxt, w_phase_nxt, 2'b00};
            c_SET_MIN:  w_blk_nxt = {2'b00, w_phase_nxt, w_phase_nxt};
            default:    w_blk_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge pCLK) begin
        if (pRST) begin
            r_bcnt      <= '0;
            r_phase     <= 1'b0;
            r_min_inc   <= 1'b0;
            r_hour_inc  <= 1'b0;
            r_sec_clr   <= 1'b0;
            r_digit_blk <= 4'b0000;
        end else begin
            r_bcnt      <= (r_bcnt == c_BLINK_LAST) ? '0 : r_bcnt + 1'b1;
            r_phase     <= w_phase_nxt;
            r_min_inc   <= w_min_inc_nxt;
            r_hour_inc  <= w_hour_inc_nxt;
            r_sec_clr   <= w_clr_ev;
            r_digit_blk <= w_blk_nxt;
        end
    end

    // CLR restarts the second; SET modes freeze it with the prescaler at 0.
    always_ff @(posedge pCLK) begin
        if (pRST) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
        end else if (w_clr_ev || (r_mode != c_RUN)) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
        end else if (r_presc == c_TICK_LAST) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b1;
        end else begin
            r_presc    <= r_presc + 1'b1;
            r_sec_tick <= 1'b0;
        end
    end

    assign sec_tick  = r_sec_tick;
    assign min_inc   = r_min_inc;
    assign hour_inc  = r_hour_inc;
    assign sec_clr   = r_sec_clr;
    assign mode      = r_mode;
    assign digit_blk = r_digit_blk;

endmodule
`default_nettype wire
